// File: rtl/sram_mem_tester_if.sv
// Avalon-MM word interface between the memory tester (master) and sram_controller (slave).
interface sram_mem_tester_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, write, writedata, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, write, writedata, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/sram_mem_tester.sv
// Two-pass write/read-back BIST master for the sram_controller Avalon-MM slave:
// pass 0 writes address-as-data, pass 1 its inverse, reads are pipelined and compared in order.
module sram_mem_tester #(
  parameter int ADDR_W          = 18,
  parameter int DATA_W          = 16,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ERR_CNT_W       = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 start_i,
  input  logic [ADDR_W-1:0]    last_addr_i,
  sram_mem_tester_if.master    mem_if,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 pass_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o,
  output logic [ADDR_W-1:0]    first_err_addr_o
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  localparam logic [3:0]           MAX_OS  = 4'(MAX_OUTSTANDING);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

  state_t               state, state_nxt;
  logic [ADDR_W-1:0]    addr, cmp_addr, last_addr, first_err_addr;
  logic                 inv;
  logic [3:0]           outstanding;
  logic [ERR_CNT_W-1:0] err_cnt;
  logic                 start_acc, wr_acc, rd_acc, rdv_ok, addr_last;

  function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a, input logic iv);
    return DATA_W'(a) ^ {DATA_W{iv}};
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (c == ERR_MAX) ? c : c + ERR_CNT_W'(1);
  endfunction

  assign start_acc = start_i && (state == S_IDLE || state == S_DONE);
  assign wr_acc    = mem_if.write && !mem_if.waitrequest;
  assign rd_acc    = mem_if.read && !mem_if.waitrequest;
  assign addr_last = (addr == last_addr);
  // Returns outside the read phases, or with nothing pending, are stale and dropped.
  assign rdv_ok    = mem_if.readdatavalid && (outstanding != 4'd0) &&
                     (state == S_READ || state == S_DRAIN);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    mem_if.write     = 1'b0;
    mem_if.read      = 1'b0;
    mem_if.address   = '0;
    mem_if.writedata = '0;
    case (state)
      S_IDLE, S_DONE: if (start_i) state_nxt = S_WRITE;
      S_WRITE: begin
        mem_if.write     = 1'b1;
        mem_if.address   = addr;
        mem_if.writedata = pat(addr, inv);
        if (!mem_if.waitrequest && addr_last) state_nxt = S_READ;
      end
      S_READ: begin
        mem_if.address = addr;
        // Outstanding cannot grow while a request stalls, so a raised read stays raised.
        if (outstanding < MAX_OS) begin
          mem_if.read = 1'b1;
          if (!mem_if.waitrequest && addr_last) state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: if (outstanding == 4'd0) state_nxt = inv ? S_DONE : S_WRITE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      addr           <= '0;
      cmp_addr       <= '0;
      last_addr      <= '0;
      inv            <= 1'b0;
      outstanding    <= 4'd0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else if (start_acc) begin
      addr           <= '0;
      cmp_addr       <= '0;
      last_addr      <= last_addr_i;
      inv            <= 1'b0;
      outstanding    <= 4'd0;
      err_cnt        <= '0;
      first_err_addr <= '0;
    end else begin
      case (state)
        S_WRITE: if (wr_acc) addr <= addr_last ? '0 : addr + ADDR_W'(1);
        S_READ:  if (rd_acc) addr <= addr_last ? '0 : addr + ADDR_W'(1);
        S_DRAIN: if (outstanding == 4'd0 && !inv) begin
          inv      <= 1'b1;
          addr     <= '0;
          cmp_addr <= '0;
        end
        default: ;
      endcase
      case ({rd_acc, rdv_ok})
        2'b10:   outstanding <= outstanding + 4'd1;
        2'b01:   outstanding <= outstanding - 4'd1;
        default: ;
      endcase
      if (rdv_ok) begin
        cmp_addr <= cmp_addr + ADDR_W'(1);
        if (mem_if.readdata != pat(cmp_addr, inv)) begin
          err_cnt <= sat_inc(err_cnt);
          if (err_cnt == '0) first_err_addr <= cmp_addr;
        end
      end
    end
  end

  assign busy_o           = (state == S_WRITE) || (state == S_READ) || (state == S_DRAIN);
  assign done_o           = (state == S_DONE);
  assign pass_o           = done_o && (err_cnt == '0);
  assign err_cnt_o        = err_cnt;
  assign first_err_addr_o = first_err_addr;

endmodule

// File: tb/tb_sram_mem_tester.sv
// Bench for sram_mem_tester: randomized Avalon slave with memory, latency and fault injection,
// checked against an expected-access list and expected error summary.
module tb_sram_mem_tester;
  localparam int AW = 18, DW = 16, MAXO = 3, EW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start;
  logic [AW-1:0] last_addr;
  logic          busy, done, pass;
  logic [EW-1:0] err_cnt;
  logic [AW-1:0] first_err;

  sram_mem_tester_if #(.ADDR_W(AW), .DATA_W(DW)) mif ();

  sram_mem_tester #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .ERR_CNT_W(EW)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .last_addr_i(last_addr),
    .mem_if(mif), .busy_o(busy), .done_o(done), .pass_o(pass),
    .err_cnt_o(err_cnt), .first_err_addr_o(first_err)
  );

  int checks = 0, failures = 0;

  // Slave configuration and observation state
  int wr_pct = 0, lat = 1, f0 = -1, f1 = -1, cur_last = 0, cyc = 0, rd_count = 0;
  int stab_viol = 0, both_viol = 0, os_viol = 0, full_cycles = 0, wr_hi_cycles = 0;
  logic [DW-1:0] mem [0:1023];
  typedef struct { logic [DW-1:0] data; int due; } rsp_t;
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } acc_t;
  rsp_t pipe[$];
  acc_t wq[$];
  logic [AW-1:0] rq[$];
  logic p_req = 1'b0, p_rd = 1'b0, p_wr = 1'b0;
  logic [AW-1:0] p_a = '0;
  logic [DW-1:0] p_d = '0;

  function automatic logic [DW-1:0] ref_pat(input int a, input int p);
    logic [DW-1:0] v;
    v = DW'(a);
    return (p != 0) ? ~v : v;
  endfunction

  always @(posedge clk) begin
    int pending;
    rsp_t r;
    logic [DW-1:0] rd;
    cyc++;
    pending = pipe.size() + (mif.readdatavalid === 1'b1 ? 1 : 0);
    if (rst_n === 1'b1) begin
      if (mif.read && mif.write) both_viol++;
      if (mif.read && pending >= MAXO) os_viol++;
      if (!mif.read && pending >= MAXO) full_cycles++;
      if (mif.write) wr_hi_cycles++;
      if (p_req && (mif.read !== p_rd || mif.write !== p_wr || mif.address !== p_a ||
                    (p_wr && mif.writedata !== p_d))) stab_viol++;
      p_req = (mif.read || mif.write) && mif.waitrequest;
      p_rd = mif.read; p_wr = mif.write; p_a = mif.address; p_d = mif.writedata;
      if (mif.write && !mif.waitrequest) begin
        mem[mif.address[9:0]] = mif.writedata;
        wq.push_back('{mif.address, mif.writedata});
      end
      if (mif.read && !mif.waitrequest) begin
        rd = mem[mif.address[9:0]];
        if ((rd_count <= cur_last && int'(mif.address) == f0) ||
            (rd_count >  cur_last && int'(mif.address) == f1)) rd = 16'h1234;
        r.data = rd;
        r.due  = cyc + lat - 1;
        pipe.push_back(r);
        rq.push_back(mif.address);
        rd_count++;
      end
    end else begin
      p_req = 1'b0;
    end
    if (pipe.size() > 0 && pipe[0].due <= cyc) begin
      mif.readdata      <= pipe[0].data;
      mif.readdatavalid <= 1'b1;
      void'(pipe.pop_front());
    end else begin
      mif.readdatavalid <= 1'b0;
    end
    mif.waitrequest <= ($urandom_range(99) < wr_pct);
  end

  task automatic clear_mon();
    wq.delete(); rq.delete();
    stab_viol = 0; both_viol = 0; os_viol = 0; full_cycles = 0; wr_hi_cycles = 0; rd_count = 0;
  endtask

  task automatic run_test(input int L, input int poke, output bit ok);
    clear_mon();
    cur_last = L;
    @(negedge clk); last_addr = AW'(L); start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL busy_after_start got=%b want=1", busy); end
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      if (done === 1'b1) begin ok = 1'b1; break; end
      if (i == poke) begin
        checks++;
        if (!(busy === 1'b1 && mif.write === 1'b1)) begin
          failures++; $display("FAIL poke_in_write busy=%b write=%b want 1/1", busy, mif.write);
        end
        last_addr = AW'(3); start = 1'b1;
      end else start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (!ok) begin failures++; $display("FAIL run_timeout L=%0d done=%b want=1", L, done); end
  endtask

  task automatic verify_run(input string name, input int L, input int fa0, input int fa1);
    int n, exp_err, exp_first, wbad, rbad, p, a;
    n = L + 1; exp_err = 0; exp_first = 0; wbad = 0; rbad = 0;
    for (int pp = 0; pp < 2; pp++)
      for (int aa = 0; aa <= L; aa++)
        if (((pp == 0 && aa == fa0) || (pp == 1 && aa == fa1)) && ref_pat(aa, pp) != 16'h1234) begin
          if (exp_err == 0) exp_first = aa;
          exp_err++;
        end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL %s_done got done=%b busy=%b want 1/0", name, done, busy);
    end
    checks++;
    if (pass !== (exp_err == 0)) begin
      failures++; $display("FAIL %s_pass got=%b want=%b", name, pass, exp_err == 0);
    end
    checks++;
    if (err_cnt !== EW'(exp_err)) begin
      failures++; $display("FAIL %s_err_cnt got=%0d want=%0d", name, err_cnt, exp_err);
    end
    checks++;
    if (first_err !== AW'(exp_first)) begin
      failures++; $display("FAIL %s_first_err got=%0d want=%0d", name, first_err, exp_first);
    end
    checks++;
    if (wq.size() != 2 * n || rq.size() != 2 * n) begin
      failures++; $display("FAIL %s_access_count writes=%0d reads=%0d want %0d each", name, wq.size(), rq.size(), 2 * n);
    end
    for (int i = 0; i < wq.size(); i++) begin
      p = i / n; a = i % n;
      if (wq[i].a !== AW'(a) || wq[i].d !== ref_pat(a, p)) wbad++;
    end
    for (int i = 0; i < rq.size(); i++) if (rq[i] !== AW'(i % n)) rbad++;
    checks++;
    if (wbad != 0 || rbad != 0) begin
      failures++; $display("FAIL %s_sequence bad_writes=%0d bad_reads=%0d want 0/0", name, wbad, rbad);
    end
    checks++;
    if (stab_viol != 0 || both_viol != 0 || os_viol != 0) begin
      failures++; $display("FAIL %s_protocol stable=%0d rd_and_wr=%0d over_outstanding=%0d want 0/0/0", name, stab_viol, both_viol, os_viol);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; last_addr = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, pass, err_cnt, first_err} !== '0) begin
      failures++; $display("FAIL reset_status got busy=%b done=%b pass=%b err=%0d first=%0d want all 0", busy, done, pass, err_cnt, first_err);
    end
    checks++;
    if ({mif.read, mif.write, mif.address, mif.writedata} !== '0) begin
      failures++; $display("FAIL reset_bus got rd=%b wr=%b addr=%0h data=%0h want all 0", mif.read, mif.write, mif.address, mif.writedata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mif.read, mif.write} !== '0) begin
      failures++; $display("FAIL idle_after_reset busy=%b done=%b rd=%b wr=%b want 0", busy, done, mif.read, mif.write);
    end
  endtask

  task automatic test_ideal();
    bit ok;
    wr_pct = 0; lat = 1; f0 = -1; f1 = -1;
    run_test(15, -1, ok);
    verify_run("ideal", 15, -1, -1);
    checks++;
    if (wr_hi_cycles != 32 || wq.size() + rq.size() != 64) begin
      failures++; $display("FAIL ideal_back_to_back write_cycles=%0d accesses=%0d want 32/64", wr_hi_cycles, wq.size() + rq.size());
    end
  endtask

  task automatic test_errors();
    bit ok;
    wr_pct = 0; lat = 1; f0 = 5; f1 = 9;
    run_test(15, -1, ok);
    verify_run("errors", 15, 5, 9);
    f0 = -1; f1 = -1;
  endtask

  task automatic test_random_wait();
    bit ok;
    int L;
    for (int it = 0; it < 5; it++) begin
      L = int'($urandom_range(40, 0));
      wr_pct = 50; lat = int'($urandom_range(6, 1));
      f0 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(L, 0)) : -1;
      f1 = ($urandom_range(1, 0) == 1) ? int'($urandom_range(L, 0)) : -1;
      run_test(L, -1, ok);
      verify_run("random_wait", L, f0, f1);
    end
    f0 = -1; f1 = -1; wr_pct = 0;
  endtask

  task automatic test_latency();
    bit ok;
    wr_pct = 0; lat = 6;
    run_test(20, -1, ok);
    verify_run("latency6", 20, -1, -1);
    checks++;
    if (full_cycles == 0) begin
      failures++; $display("FAIL latency6_throttle read_off_while_full_cycles=%0d want >0", full_cycles);
    end
  endtask

  task automatic test_start_mid();
    bit ok;
    wr_pct = 30; lat = 2;
    run_test(30, 4, ok);
    verify_run("start_mid", 30, -1, -1);
    wr_pct = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int stale;
    wr_pct = 0; lat = 6; clear_mon(); cur_last = 20;
    @(negedge clk); last_addr = AW'(20); start = 1'b1;
    @(negedge clk); start = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (pipe.size() + (mif.readdatavalid ? 1 : 0) == 3) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL reach_3_outstanding got=%0d want=3", pipe.size()); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, pass, err_cnt, first_err, mif.read, mif.write, mif.address, mif.writedata} !== '0) begin
      failures++; $display("FAIL midreset_immediate busy=%b rd=%b wr=%b addr=%0h want all 0", busy, mif.read, mif.write, mif.address);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, pass, err_cnt, first_err, mif.read, mif.write, mif.address} !== '0) begin
      failures++; $display("FAIL midreset_held busy=%b rd=%b wr=%b addr=%0h want all 0", busy, mif.read, mif.write, mif.address);
    end
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mif.readdatavalid === 1'b1) stale++;
      if (pipe.size() == 0 && mif.readdatavalid !== 1'b1) break;
    end
    checks++;
    if (stale == 0 || busy !== 1'b0 || done !== 1'b0 || err_cnt !== '0) begin
      failures++; $display("FAIL stale_rdv_ignored stale=%0d busy=%b done=%b err=%0d want >0/0/0/0", stale, busy, done, err_cnt);
    end
    lat = 1;
    run_test(0, -1, ok);
    verify_run("after_reset_l0", 0, -1, -1);
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_errors();
    test_random_wait();
    test_latency();
    test_start_mid();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
